sha256_job_scheduler: RTL
=========================

# sha256_job_scheduler

Round-robin job scheduler that shares one `sha256` register-mapped core among `NREQ` requesters. It sits between the requesters and the core's `cs/we/address/write_data/read_data` bus. For each granted job it latches a 512-bit block, writes it into the core, issues init or next, polls status, reads back the digest and returns it to the requester. Multi-block messages lock the core to their owner until the message's last block completes, so chaining state is never interleaved.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1023: maximum poll cycles per job before it is abandoned.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset. One clock `clk`; reset `reset` is synchronous and active-high.
- `req_valid` in NREQ: job pending, one bit per requester.
- `req_first` in NREQ: block starts a message (init); 0 = continuation (next).
- `req_last` in NREQ: block ends a message (releases lock).
- `req_mode` in NREQ: 1 = SHA-256, 0 = SHA-224.
- `req_block` in NREQ*512: requester i occupies bits [i*512 +: 512]; word 0 = [511:480].
- `req_ack` out NREQ: one-cycle pulse when the block is latched. The requester may drop or change inputs afterwards.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_id` out clog2(NREQ): requester served.
- `rsp_digest` out 256: digest, word 0 in [255:224].
- `rsp_error` out 1: timeout; digest forced to 0.
- `busy` out 1: state != IDLE.
- `cs`, `we` out 1: core bus control.
- `address` out 8: core register address.
- `write_data` out 32: core write data.
- `read_data` in 32: core read data, combinational, sampled in the same cycle `cs=1, we=0`.

## Operation
- Core register map used: 0x10–0x1F block words 0–15; 0x08 CTRL {irq_en=bit3, mode=bit2, next=bit1, init=bit0}; 0x09 STATUS {valid=bit1, ready=bit0}; 0x20–0x27 digest words 0–7.
- **Arbitration (IDLE):**
  - Eligible set = all `req_valid` bits, or only the owner's bit when `locked`.
  - Grant the first eligible index at or after `rr_ptr`, wrapping modulo NREQ.
  - On grant: pulse `req_ack[i]`; latch block, first, last, mode and id; set `rr_ptr = (i+1) mod NREQ`; go to LOAD.
- **LOAD (16 cycles):** `cs=1, we=1`, `address = 0x10+k`, `write_data = word k`, k = 0..15.
- **CTRL (1 cycle):** write 0x08 with `{28'h0, 1'b0, mode, ~first, first}`.
- **WAIT_BUSY:** each cycle read 0x09. Exit to WAIT_DONE when ready=0.
- **WAIT_DONE:** each cycle read 0x09. Exit to READ when ready=1 and valid=1.
- **Timeout:** a single poll counter covers WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT, go to RESP with error.
- **READ (8 cycles):** read 0x20+k and capture `read_data` into digest word k.
- **RESP (1 cycle):** `rsp_valid=1`, then go to IDLE.
  - Lock update: `locked = ~last & ~error`; owner = id.
  - An error always clears the lock.
- **Idle bus:** `cs=0, we=0, address=0, write_data=0` whenever the controller is not accessing the core.
- **Locked owner with `req_valid=0`:** the controller waits in IDLE indefinitely. Other requesters are not served.
- **`req_first=1` from the locked owner:** accepted; acts as a fresh init and the lock re-evaluates.

## Timing
- Reset values: every output 0 (`req_ack`, `rsp_*`, `busy`, `cs`, `we`, `address`, `write_data`); `rr_ptr=0`, `locked=0`, state IDLE.
- Reset mid-job:
  - Abort immediately; no `rsp_valid` is issued.
  - System reset must also reset the core.
- Grant latency: `req_ack` is asserted in the first IDLE cycle in which the requester is eligible.
- Job latency from the ack cycle: 1 (ack) + 16 + 1 + poll cycles + 8 + 1 = 27 + P cycles.
- `rsp_valid` never coincides with `req_ack`. At most one job is in flight.

## Test plan
- **"abc" SHA-256:** req0 sends block 61626380, 13×00000000, 00000000, 00000018 with first=1, last=1, mode=1. Required: `rsp_id=0`, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, `rsp_error=0`.
- **"abc" SHA-224:** same block with mode=0. Required: words 0–6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; CTRL write data = 0x00000001.
- **Lock:**
  - req1 sends the 448-bit NIST message ("abcdbcdecdef…nopq"): block 1 with first=1, last=0.
  - req0 becomes valid during that job.
  - Required: req1's second block (first=0, last=1, CTRL = 0x00000006) is granted before req0.
  - Final req1 digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **Round-robin:** all 4 requesters hold valid single-block jobs continuously. Required: grant order 0, 1, 2, 3, 0, 1.
- **Timeout:** stub core returns STATUS=0x1 forever, TIMEOUT=20. Required: `rsp_error=1` and digest 0 after 20 poll cycles; lock cleared.
- **Reset mid-LOAD:** assert `reset` at LOAD word 7. Required: next cycle all outputs 0, `busy=0`; a subsequent "abc" job returns the correct digest.

Source files
------------

// File: rtl/sha256_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sha256_job_scheduler
// Purpose  : Round-robin scheduler that shares one register-mapped sha256
//            core among NREQ requesters. A granted 512-bit block is latched,
//            written into the core, init/next is issued, STATUS is polled,
//            and the digest is read back and returned with the requester id.
//            A multi-block message locks the core to its owner until the
//            message's last block completes.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            req_valid/first/last/
//            mode/block             - per-requester job request
//            req_ack                - one-cycle pulse when a block is latched
//            rsp_valid/id/digest/
//            error                  - one-cycle response strobe and payload
//            busy                   - controller not idle
//            cs/we/address/
//            write_data/read_data   - core register bus
// Revision : 1.0 - initial release
// ============================================================================
module sha256_job_scheduler #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_first,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ-1:0]         req_mode,
   input  logic [NREQ*512-1:0]     req_block,
   output logic [NREQ-1:0]         req_ack,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [255:0]            rsp_digest,
   output logic                    rsp_error,
   output logic                    busy,
   output logic                    cs,
   output logic                    we,
   output logic [7:0]              address,
   output logic [31:0]             write_data,
   input  logic [31:0]             read_data
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = $clog2(TIMEOUT + 1);
   localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
   localparam logic [PW-1:0]  POLL_LAST = PW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_CTRL      = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_READ      = 3'd5,
      S_RESP      = 3'd6
   } state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  rr_ptr, owner, job_id;
   logic            locked, job_first, job_last, job_mode, job_err;
   logic [511:0]    job_block;
   logic [255:0]    digest;
   logic [3:0]      beat;
   logic [PW-1:0]   poll_cnt;
   logic            poll_expire;

   logic [NREQ-1:0] eligible;
   logic            grant_hit;
   logic [IDW-1:0]  grant_id;
   logic [IDW:0]    scan;
   logic [511:0]    grant_block;

   // Rotating priority search starting at rr_ptr; a locked core only
   // considers its owner so chained blocks are never interleaved.
   always_comb begin
      eligible    = locked ? (req_valid & (NREQ'(1) << owner)) : req_valid;
      grant_hit   = 1'b0;
      grant_id    = '0;
      scan        = '0;
      grant_block = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan >= (IDW+1)'(NREQ))
            scan = scan - (IDW+1)'(NREQ);
         if (!grant_hit && eligible[scan[IDW-1:0]]) begin
            grant_hit = 1'b1;
            grant_id  = scan[IDW-1:0];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i))
            grant_block = req_block[i*512 +: 512];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req_ack     = '0;
      rsp_valid   = 1'b0;
      rsp_id      = '0;
      rsp_digest  = '0;
      rsp_error   = 1'b0;
      cs          = 1'b0;
      we          = 1'b0;
      address     = '0;
      write_data  = '0;
      poll_expire = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            // Gated by reset so no ack is shown for a job that is not latched.
            if (grant_hit && !reset) begin
               req_ack   = NREQ'(1) << grant_id;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            cs         = 1'b1;
            we         = 1'b1;
            address    = 8'h10 + {4'h0, beat};
            write_data = job_block[511:480];
            if (beat == 4'd15)
               state_nxt = S_CTRL;
         end
         S_CTRL: begin
            cs         = 1'b1;
            we         = 1'b1;
            address    = 8'h08;
            write_data = {28'h0, 1'b0, job_mode, ~job_first, job_first};
            state_nxt  = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            cs      = 1'b1;
            address = 8'h09;
            if (!read_data[0]) begin
               state_nxt = S_WAIT_DONE;
            end else if (poll_cnt == POLL_LAST) begin
               state_nxt   = S_RESP;
               poll_expire = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            cs      = 1'b1;
            address = 8'h09;
            if (read_data[1:0] == 2'b11) begin
               state_nxt = S_READ;
            end else if (poll_cnt == POLL_LAST) begin
               state_nxt   = S_RESP;
               poll_expire = 1'b1;
            end
         end
         S_READ: begin
            cs      = 1'b1;
            address = 8'h20 + {4'h0, beat};
            if (beat == 4'd7)
               state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid  = 1'b1;
            rsp_id     = job_id;
            rsp_error  = job_err;
            rsp_digest = job_err ? 256'h0 : digest;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr    <= '0;
         owner     <= '0;
         locked    <= 1'b0;
         job_id    <= '0;
         job_first <= 1'b0;
         job_last  <= 1'b0;
         job_mode  <= 1'b0;
         job_err   <= 1'b0;
         job_block <= '0;
         digest    <= '0;
         beat      <= '0;
         poll_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_hit) begin
                  job_id    <= grant_id;
                  job_first <= req_first[grant_id];
                  job_last  <= req_last[grant_id];
                  job_mode  <= req_mode[grant_id];
                  job_block <= grant_block;
                  job_err   <= 1'b0;
                  beat      <= '0;
                  rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
               end
            end
            S_LOAD: begin
               // Shift so the next word is always in the top 32 bits; beat
               // wraps from 15 to 0, ready for the digest read phase.
               job_block <= {job_block[479:0], 32'h0};
               beat      <= beat + 4'd1;
            end
            S_CTRL: poll_cnt <= '0;
            S_WAIT_BUSY, S_WAIT_DONE: begin
               poll_cnt <= poll_cnt + 1'b1;
               if (poll_expire)
                  job_err <= 1'b1;
            end
            S_READ: begin
               digest <= {digest[223:0], read_data};
               beat   <= beat + 4'd1;
            end
            S_RESP: begin
               locked <= ~job_last & ~job_err;
               owner  <= job_id;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
